// File: rtl/fp_accum_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_accum_driver_if
// Description : Handshake bundle for fp_accum_driver: term input stream,
//               operand/result channels to an external float adder, and the
//               batch-sum output channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_accum_driver_if;
  // term input stream
  logic [31:0] in_data;
  logic        in_stb;
  logic        in_ack;
  // adder operand a (accumulator)
  logic [31:0] adder_a;
  logic        adder_a_stb;
  logic        adder_a_ack;
  // adder operand b (term)
  logic [31:0] adder_b;
  logic        adder_b_stb;
  logic        adder_b_ack;
  // adder result
  logic [31:0] adder_z;
  logic        adder_z_stb;
  logic        adder_z_ack;
  // batch sum output
  logic [31:0] sum_out;
  logic        sum_stb;
  logic        sum_ack;

  // accumulator driver side
  modport master (
    input  in_data, in_stb,
    output in_ack,
    output adder_a, adder_a_stb,
    input  adder_a_ack,
    output adder_b, adder_b_stb,
    input  adder_b_ack,
    input  adder_z, adder_z_stb,
    output adder_z_ack,
    output sum_out, sum_stb,
    input  sum_ack
  );

  // environment side: term producer, float adder and sum consumer
  modport slave (
    output in_data, in_stb,
    input  in_ack,
    input  adder_a, adder_a_stb,
    output adder_a_ack,
    input  adder_b, adder_b_stb,
    output adder_b_ack,
    output adder_z, adder_z_stb,
    input  adder_z_ack,
    input  sum_out, sum_stb,
    output sum_ack
  );
endinterface
`default_nettype wire

// File: rtl/fp_accum_driver.sv
`default_nettype none
// ============================================================================
// Module      : fp_accum_driver
// Description : Sequences batches of N_TERMS float32 terms through an external
//               float adder, accumulating into acc and presenting each batch
//               sum on a stb/ack output. No arithmetic is done locally.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_accum_driver #(
  parameter int N_TERMS = 4
) (
  input  logic               clk,
  input  logic               rst,
  fp_accum_driver_if.master  bus
);

  localparam logic [7:0] c_n_terms = 8'(N_TERMS);

  typedef enum logic [1:0] {
    S_GET_IN  = 2'd0,
    S_SEND_OP = 2'd1,
    S_WAIT_Z  = 2'd2,
    S_PUT_SUM = 2'd3
  } state_t;

  state_t      r_state,       w_state_nx;
  logic [31:0] r_acc,         w_acc_nx;
  logic [31:0] r_term,        w_term_nx;
  logic [7:0]  r_cnt,         w_cnt_nx;
  logic        r_in_ack,      w_in_ack_nx;
  logic [31:0] r_adder_a,     w_adder_a_nx;
  logic        r_adder_a_stb, w_adder_a_stb_nx;
  logic [31:0] r_adder_b,     w_adder_b_nx;
  logic        r_adder_b_stb, w_adder_b_stb_nx;
  logic        r_adder_z_ack, w_adder_z_ack_nx;
  logic [31:0] r_sum_out,     w_sum_out_nx;
  logic        r_sum_stb,     w_sum_stb_nx;
  logic [7:0]  w_cnt_inc;

  assign w_cnt_inc = r_cnt + 8'd1;

  // Next-state and next-output decode. Each state's handshake flag is low on
  // entry, so "flag low" marks the first edge spent in that state.
  always_comb begin
    w_state_nx       = r_state;
    w_acc_nx         = r_acc;
    w_term_nx        = r_term;
    w_cnt_nx         = r_cnt;
    w_in_ack_nx      = r_in_ack;
    w_adder_a_nx     = r_adder_a;
    w_adder_a_stb_nx = r_adder_a_stb;
    w_adder_b_nx     = r_adder_b;
    w_adder_b_stb_nx = r_adder_b_stb;
    w_adder_z_ack_nx = r_adder_z_ack;
    w_sum_out_nx     = r_sum_out;
    w_sum_stb_nx     = r_sum_stb;

    case (r_state)
      S_GET_IN: begin
        if (!r_in_ack) begin
          w_in_ack_nx = 1'b1;
        end else if (bus.in_stb) begin
          w_term_nx   = bus.in_data;
          w_in_ack_nx = 1'b0;
          w_state_nx  = S_SEND_OP;
        end
      end

      S_SEND_OP: begin
        // Both strobes low only on entry: we leave as soon as both drain.
        if (!r_adder_a_stb && !r_adder_b_stb) begin
          w_adder_a_nx     = r_acc;
          w_adder_b_nx     = r_term;
          w_adder_a_stb_nx = 1'b1;
          w_adder_b_stb_nx = 1'b1;
        end else begin
          w_adder_a_stb_nx = r_adder_a_stb & ~bus.adder_a_ack;
          w_adder_b_stb_nx = r_adder_b_stb & ~bus.adder_b_ack;
          if (!w_adder_a_stb_nx && !w_adder_b_stb_nx) begin
            w_state_nx = S_WAIT_Z;
          end
        end
      end

      S_WAIT_Z: begin
        if (!r_adder_z_ack) begin
          w_adder_z_ack_nx = 1'b1;
        end else if (bus.adder_z_stb) begin
          w_acc_nx         = bus.adder_z;
          w_cnt_nx         = w_cnt_inc;
          w_adder_z_ack_nx = 1'b0;
          w_state_nx       = (w_cnt_inc == c_n_terms) ? S_PUT_SUM : S_GET_IN;
        end
      end

      S_PUT_SUM: begin
        if (!r_sum_stb) begin
          w_sum_out_nx = r_acc;
          w_sum_stb_nx = 1'b1;
        end else if (bus.sum_ack) begin
          w_sum_stb_nx = 1'b0;
          w_acc_nx     = 32'h0000_0000;
          w_cnt_nx     = 8'd0;
          w_state_nx   = S_GET_IN;
        end
      end

      default: begin
        w_state_nx = S_GET_IN;
      end
    endcase
  end

  // State and output registers; reset discards any partial batch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_GET_IN;
      r_acc         <= 32'h0000_0000;
      r_term        <= 32'h0000_0000;
      r_cnt         <= 8'd0;
      r_in_ack      <= 1'b0;
      r_adder_a     <= 32'h0000_0000;
      r_adder_a_stb <= 1'b0;
      r_adder_b     <= 32'h0000_0000;
      r_adder_b_stb <= 1'b0;
      r_adder_z_ack <= 1'b0;
      r_sum_out     <= 32'h0000_0000;
      r_sum_stb     <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_acc         <= w_acc_nx;
      r_term        <= w_term_nx;
      r_cnt         <= w_cnt_nx;
      r_in_ack      <= w_in_ack_nx;
      r_adder_a     <= w_adder_a_nx;
      r_adder_a_stb <= w_adder_a_stb_nx;
      r_adder_b     <= w_adder_b_nx;
      r_adder_b_stb <= w_adder_b_stb_nx;
      r_adder_z_ack <= w_adder_z_ack_nx;
      r_sum_out     <= w_sum_out_nx;
      r_sum_stb     <= w_sum_stb_nx;
    end
  end

  assign bus.in_ack      = r_in_ack;
  assign bus.adder_a     = r_adder_a;
  assign bus.adder_a_stb = r_adder_a_stb;
  assign bus.adder_b     = r_adder_b;
  assign bus.adder_b_stb = r_adder_b_stb;
  assign bus.adder_z_ack = r_adder_z_ack;
  assign bus.sum_out     = r_sum_out;
  assign bus.sum_stb     = r_sum_stb;

endmodule
`default_nettype wire
